// File: rtl/keypad_scan_if.sv
// rtl/keypad_scan_if.sv - key event and display-value bundle of the keypad scanner
interface keypad_scan_if;
    logic        clr;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_down;
    logic [31:0] value;

    // scanner side: produces key events and the display value, takes the clear
    modport master (
        input  clr,
        output key_code,
        output key_valid,
        output key_down,
        output value
    );

    // consumer side: display/host logic
    modport slave (
        output clr,
        input  key_code,
        input  key_valid,
        input  key_down,
        input  value
    );
endinterface

// File: rtl/keypad_scan.sv
// rtl/keypad_scan.sv - 4x4 matrix keypad scanner with debounce and optional hex-digit accumulator
// Optional feature macro: KEYPAD_ACCUM_EN (shifts each accepted key code into value).
module keypad_scan #(
    parameter logic [19:0] SCAN_T  = 20'd199999,
    parameter int unsigned DEB_CNT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [3:0]    col_in,
    output logic [3:0]    row_out,
    keypad_scan_if.master kp
);
    typedef enum logic [1:0] {
        SCAN      = 2'd0,
        DEB_PRESS = 2'd1,
        HELD      = 2'd2,
        DEB_REL   = 2'd3
    } state_t;

    localparam logic [3:0] DEB_MAX = 4'(DEB_CNT);

    logic [3:0]  col_meta_q, col_meta_d;
    logic [3:0]  col_s_q, col_s_d;
    logic [19:0] cnt_q, cnt_d;
    logic        tick;
    state_t      state_q, state_d;
    logic [1:0]  row_idx_q, row_idx_d;
    logic [1:0]  col_idx_q, col_idx_d;
    logic [3:0]  deb_q, deb_d;
    logic [3:0]  key_code_q, key_code_d;
    logic        key_valid_q, key_valid_d;
    logic        key_down_q, key_down_d;
    logic        any_low;
    logic [1:0]  low_idx;
    logic        col_hit;
    logic [3:0]  deb_inc;

    assign tick    = (cnt_q == SCAN_T);
    assign col_hit = ~col_s_q[col_idx_q];
    assign deb_inc = deb_q + 4'd1;
    assign row_out = ~(4'b0001 << row_idx_q);

    // two-stage synchronizer for the asynchronous column inputs, plus the tick counter
    always_comb begin
        col_meta_d = col_in;
        col_s_d    = col_meta_q;
        cnt_d      = tick ? 20'd0 : cnt_q + 20'd1;
    end

    // pick the lowest-index low column on the driven row
    always_comb begin
        any_low = (col_s_q != 4'b1111);
        low_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!col_s_q[i]) begin
                low_idx = 2'(i);
            end
        end
    end

    // scan/debounce FSM; row_idx is simply left alone once a key is found, which freezes the row
    always_comb begin
        state_d     = state_q;
        row_idx_d   = row_idx_q;
        col_idx_d   = col_idx_q;
        deb_d       = deb_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_down_d  = key_down_q;
        if (tick) begin
            unique case (state_q)
                SCAN: begin
                    if (any_low) begin
                        col_idx_d = low_idx;
                        deb_d     = 4'd1;
                        if (DEB_MAX == 4'd1) begin
                            state_d     = HELD;
                            key_code_d  = {row_idx_q, low_idx};
                            key_down_d  = 1'b1;
                            key_valid_d = 1'b1;
                        end else begin
                            state_d = DEB_PRESS;
                        end
                    end else begin
                        row_idx_d = row_idx_q + 2'd1;
                    end
                end
                DEB_PRESS: begin
                    if (col_hit) begin
                        deb_d = deb_inc;
                        if (deb_inc == DEB_MAX) begin
                            state_d     = HELD;
                            key_code_d  = {row_idx_q, col_idx_q};
                            key_down_d  = 1'b1;
                            key_valid_d = 1'b1;
                        end
                    end else begin
                        state_d = SCAN;
                    end
                end
                HELD: begin
                    if (!col_hit) begin
                        deb_d = 4'd1;
                        if (DEB_MAX == 4'd1) begin
                            state_d    = SCAN;
                            key_down_d = 1'b0;
                        end else begin
                            state_d = DEB_REL;
                        end
                    end
                end
                DEB_REL: begin
                    if (!col_hit) begin
                        deb_d = deb_inc;
                        if (deb_inc == DEB_MAX) begin
                            state_d    = SCAN;
                            key_down_d = 1'b0;
                        end
                    end else begin
                        state_d = HELD;
                    end
                end
                default: state_d = SCAN;
            endcase
        end
    end

    // state registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_meta_q  <= 4'b1111;
            col_s_q     <= 4'b1111;
            cnt_q       <= 20'd0;
            state_q     <= SCAN;
            row_idx_q   <= 2'd0;
            col_idx_q   <= 2'd0;
            deb_q       <= 4'd0;
            key_code_q  <= 4'd0;
            key_valid_q <= 1'b0;
            key_down_q  <= 1'b0;
        end else begin
            col_meta_q  <= col_meta_d;
            col_s_q     <= col_s_d;
            cnt_q       <= cnt_d;
            state_q     <= state_d;
            row_idx_q   <= row_idx_d;
            col_idx_q   <= col_idx_d;
            deb_q       <= deb_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_down_q  <= key_down_d;
        end
    end

    assign kp.key_code  = key_code_q;
    assign kp.key_valid = key_valid_q;
    assign kp.key_down  = key_down_q;

`ifdef KEYPAD_ACCUM_EN
    logic [31:0] value_q, value_d;

    // shift the accepted key into the low nibble; clear takes priority over a same-cycle key
    always_comb begin
        value_d = value_q;
        if (kp.clr) begin
            value_d = 32'd0;
        end else if (key_valid_q) begin
            value_d = {value_q[27:0], key_code_q};
        end
    end

    // accumulator register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_q <= 32'd0;
        end else begin
            value_q <= value_d;
        end
    end

    assign kp.value = value_q;
`else
    logic unused_clr;
    assign unused_clr = kp.clr;
    assign kp.value   = 32'd0;
`endif
endmodule
